// File: rtl/bs_sched.sv
// bs_sched: round-robin merge of two accumulator requesters into one rounded/saturated 16-bit result stream.
// Two-cycle latency; full-rate under i_0_ack, stalls back to t_x_ack; BS_SCHED_SAT_CNT_EN adds saturation counters.
module bs_sched #(
  parameter int T_DAT_WIDTH = 36,
  parameter int I_DAT_WIDTH = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [T_DAT_WIDTH-1:0] t_0_dat,
  input  logic [T_DAT_WIDTH-1:0] t_1_dat,
  input  logic                   t_0_req,
  input  logic                   t_1_req,
  output logic                   t_0_ack,
  output logic                   t_1_ack,
  input  logic [7:0]             t_cfg_0_dat,
  input  logic [7:0]             t_cfg_1_dat,
  output logic [I_DAT_WIDTH:0]   i_0_dat,
  output logic                   i_0_req,
  input  logic                   i_0_ack,
  input  logic                   cnt_clr,
  output logic [CNT_WIDTH-1:0]   sat_cnt_0,
  output logic [CNT_WIDTH-1:0]   sat_cnt_1
);

  localparam int SH_W = 6;
  localparam logic [SH_W-1:0] RND_MAX    = SH_W'(T_DAT_WIDTH - 2);
  localparam logic [SH_W-1:0] PRESAT_LIM = SH_W'(T_DAT_WIDTH - I_DAT_WIDTH);
  localparam logic [SH_W-1:0] MSB_OFS    = SH_W'(I_DAT_WIDTH - 1);
  localparam logic [I_DAT_WIDTH-1:0] POS_MAX = {1'b0, {(I_DAT_WIDTH-1){1'b1}}};
  localparam logic [I_DAT_WIDTH-1:0] NEG_MAX = {1'b1, {(I_DAT_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [T_DAT_WIDTH-1:0] dat;
    logic [6:0]             cfg;
    logic                   src;
  } s1_t;

  s1_t                  s1;
  logic                 s1_vld;
  logic                 out_vld;
  logic [I_DAT_WIDTH:0] out_dat;
  logic                 rr_pri;
  logic                 out_can;
  logic                 s1_can;
  logic                 gnt_0;
  logic                 gnt_1;
  logic                 acc;

  assign out_can = ~out_vld | i_0_ack;
  assign s1_can  = ~s1_vld | out_can;

  // rr_pri names the requester that wins a tie
  assign gnt_0   = t_0_req & (~t_1_req | ~rr_pri);
  assign gnt_1   = t_1_req & (~t_0_req | rr_pri);
  assign t_0_ack = gnt_0 & s1_can & ~reset;
  assign t_1_ack = gnt_1 & s1_can & ~reset;
  assign acc     = t_0_ack | t_1_ack;

  assign i_0_req = out_vld;
  assign i_0_dat = out_dat;

  logic [SH_W-1:0]               sh;
  logic signed [T_DAT_WIDTH-1:0] sdat;
  logic signed [T_DAT_WIDTH-1:0] hi;
  logic [I_DAT_WIDTH-1:0]        shifted;
  logic [I_DAT_WIDTH-1:0]        res;
  logic                          rnd;
  logic                          presat;
  logic                          carry;
  logic                          neg;
  logic                          clamp;
  logic                          sat;

  assign sh      = s1.cfg[SH_W-1:0];
  assign sdat    = s1.dat;
  assign shifted = I_DAT_WIDTH'(sdat >>> sh);
  assign rnd     = (sh != '0) && (sh <= RND_MAX) && 1'(sdat >>> (sh - SH_W'(1)));
  // hi holds the bits above the result MSB, sign-extended; they must all match to fit
  assign hi      = sdat >>> (sh + MSB_OFS);
  assign presat  = (sh < PRESAT_LIM) && !((&hi) || !(|hi));
  assign carry   = rnd && (shifted == POS_MAX);
  assign sat     = presat | carry;
  assign neg     = s1.dat[T_DAT_WIDTH-1];
  assign clamp   = s1.cfg[6] & neg;

  always_comb begin
    res = shifted + {{(I_DAT_WIDTH-1){1'b0}}, rnd};
    if (clamp) begin
      res = '0;
    end else if (sat) begin
      res = neg ? NEG_MAX : POS_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= '0;
      s1_vld  <= 1'b0;
      out_vld <= 1'b0;
      out_dat <= '0;
      rr_pri  <= 1'b0;
    end else begin
      if (acc) begin
        s1_vld <= 1'b1;
        rr_pri <= t_0_ack;
        if (t_0_ack) begin
          s1 <= '{dat: t_0_dat, cfg: t_cfg_0_dat[6:0], src: 1'b0};
        end else begin
          s1 <= '{dat: t_1_dat, cfg: t_cfg_1_dat[6:0], src: 1'b1};
        end
      end else if (out_can) begin
        s1_vld <= 1'b0;
      end
      if (out_can) begin
        out_vld <= s1_vld;
        if (s1_vld) begin
          out_dat <= {s1.src, res};
        end
      end
    end
  end

`ifdef BS_SCHED_SAT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_0;
  logic [CNT_WIDTH-1:0] cnt_1;
  logic                 sat_mv;

  // clamped results never count, even if the raw value would have saturated
  assign sat_mv = s1_vld & out_can & sat & ~clamp;

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      cnt_0 <= '0;
      cnt_1 <= '0;
    end else if (sat_mv) begin
      if (!s1.src && !(&cnt_0)) cnt_0 <= cnt_0 + CNT_WIDTH'(1);
      if (s1.src && !(&cnt_1))  cnt_1 <= cnt_1 + CNT_WIDTH'(1);
    end
  end

  assign sat_cnt_0 = cnt_0;
  assign sat_cnt_1 = cnt_1;
`else
  assign sat_cnt_0 = '0;
  assign sat_cnt_1 = '0;
`endif

endmodule

// File: tb/tb_bs_sched.sv
// Bench for bs_sched: hand-computed vector table, scoreboard-checked output stream, and pipeline corner sequences.
module tb_bs_sched;

`ifdef BS_SCHED_SAT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [35:0] t_0_dat, t_1_dat;
  logic        t_0_req, t_1_req;
  logic        t_0_ack, t_1_ack;
  logic [7:0]  t_cfg_0_dat, t_cfg_1_dat;
  logic [16:0] i_0_dat;
  logic        i_0_req;
  logic        i_0_ack;
  logic        cnt_clr;
  logic [15:0] sat_cnt_0, sat_cnt_1;

  always #5 clk = ~clk;

  bs_sched dut (
    .clk(clk), .reset(reset),
    .t_0_dat(t_0_dat), .t_1_dat(t_1_dat),
    .t_0_req(t_0_req), .t_1_req(t_1_req),
    .t_0_ack(t_0_ack), .t_1_ack(t_1_ack),
    .t_cfg_0_dat(t_cfg_0_dat), .t_cfg_1_dat(t_cfg_1_dat),
    .i_0_dat(i_0_dat), .i_0_req(i_0_req), .i_0_ack(i_0_ack),
    .cnt_clr(cnt_clr), .sat_cnt_0(sat_cnt_0), .sat_cnt_1(sat_cnt_1)
  );

  typedef struct {
    logic        src;
    logic [35:0] dat;
    logic [7:0]  cfg;
    logic [16:0] exp;
    logic        sat;
  } vec_t;

  vec_t        vt[13];
  logic [16:0] sbq[$];
  logic        gq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_sat0 = 0;
  int          exp_sat1 = 0;
  int          left0, left1;
  logic        last_oreq;
  logic [16:0] last_odat;
  logic        prev_hold = 1'b0;
  logic [16:0] prev_dat;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Integer reference: floor shift, round-half-up, range saturation.
  function automatic logic [16:0] model(input logic src, input logic [35:0] d,
                                        input logic [7:0] c, output logic s);
    longint     x, f;
    int         sh;
    logic       rb;
    logic [15:0] r;
    x  = longint'($signed(d));
    sh = int'(c[5:0]);
    s  = 1'b0;
    if (c[6] && d[35]) begin
      r = 16'h0000;
    end else if (sh >= 35) begin
      r = d[35] ? 16'hFFFF : 16'h0000;
    end else begin
      f  = x >>> sh;
      rb = (sh == 0) ? 1'b0 : d[sh-1];
      if (f > 32767 || f < -32768) begin
        s = 1'b1;
        r = d[35] ? 16'h8000 : 16'h7FFF;
      end else if (f + longint'(rb) > 32767) begin
        s = 1'b1;
        r = 16'h7FFF;
      end else begin
        f = f + longint'(rb);
        r = f[15:0];
      end
    end
    return {src, r};
  endfunction

  function automatic logic [35:0] rnd36();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[35:0];
  endfunction

  task automatic expect_txn(input logic src, input logic [35:0] d, input logic [7:0] c);
    logic s;
    logic [16:0] e;
    e = model(src, d, c, s);
    sbq.push_back(e);
    if (s) begin
      if (src) exp_sat1++;
      else     exp_sat0++;
    end
  endtask

  // Output side: pop and compare on each transfer, and check hold while stalled.
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_req", {35'd0, i_0_req}, 36'd1);
        check("hold_dat", {19'd0, i_0_dat}, {19'd0, prev_dat});
      end
      if (i_0_req && i_0_ack) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got %h, expected no result", i_0_dat);
        end else begin
          check("result", {19'd0, i_0_dat}, {19'd0, sbq.pop_front()});
        end
      end
      prev_hold = i_0_req && !i_0_ack;
      prev_dat  = i_0_dat;
    end
  end

  // One cycle of requester activity: accepts are logged at the negedge, new data at posedge+1.
  task automatic step();
    logic a0, a1;
    @(negedge clk);
    a0 = t_0_ack;
    a1 = t_1_ack;
    last_oreq = i_0_req;
    last_odat = i_0_dat;
    if (a0 && a1) check("ack_both", 36'd1, 36'd0);
    if (a0) begin expect_txn(1'b0, t_0_dat, t_cfg_0_dat); gq.push_back(1'b0); left0--; end
    if (a1) begin expect_txn(1'b1, t_1_dat, t_cfg_1_dat); gq.push_back(1'b1); left1--; end
    @(posedge clk); #1;
    if (a0) begin
      if (left0 > 0) begin t_0_dat = rnd36(); t_cfg_0_dat = 8'($urandom); end
      else t_0_req = 1'b0;
    end
    if (a1) begin
      if (left1 > 0) begin t_1_dat = rnd36(); t_cfg_1_dat = 8'($urandom); end
      else t_1_req = 1'b0;
    end
  endtask

  task automatic start_both(input int n0, input int n1);
    left0 = n0; left1 = n1;
    t_0_dat = rnd36(); t_cfg_0_dat = 8'($urandom);
    t_1_dat = rnd36(); t_cfg_1_dat = 8'($urandom);
    t_0_req = (n0 > 0);
    t_1_req = (n1 > 0);
  endtask

  task automatic send(input vec_t v);
    bit got = 0;
    if (v.src) begin t_1_dat = v.dat; t_cfg_1_dat = v.cfg; t_1_req = 1'b1; end
    else       begin t_0_dat = v.dat; t_cfg_0_dat = v.cfg; t_0_req = 1'b1; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (v.src ? t_1_ack : t_0_ack) begin
        got = 1;
        sbq.push_back(v.exp);
        if (v.sat) begin
          if (v.src) exp_sat1++;
          else       exp_sat0++;
        end
      end
    end
    if (!got) check("send_timeout", 36'd0, 36'd1);
    @(posedge clk); #1;
    t_0_req = 1'b0;
    t_1_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_sat0 = 0;
    exp_sat1 = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0]  hist;
    logic [3:0]  go;
    logic [16:0] d2;
    bit          got;

    vt[0]  = '{1'b0, 36'h000000128, 8'h04, 17'h00013, 1'b0};
    vt[1]  = '{1'b0, 36'h000010000, 8'h00, 17'h07FFF, 1'b1};
    vt[2]  = '{1'b0, 36'h00000FFFF, 8'h01, 17'h07FFF, 1'b1};
    vt[3]  = '{1'b1, 36'hFFFFFFF00, 8'h04, 17'h1FFF0, 1'b0};
    vt[4]  = '{1'b1, 36'hFFFFFFF00, 8'h44, 17'h10000, 1'b0};
    vt[5]  = '{1'b1, 36'h800000000, 8'h00, 17'h18000, 1'b1};
    vt[6]  = '{1'b0, 36'h812345678, 8'h24, 17'h0FFFF, 1'b0};
    vt[7]  = '{1'b0, 36'h7FFFFFFFF, 8'h3F, 17'h00000, 1'b0};
    vt[8]  = '{1'b1, 36'h000001280, 8'h88, 17'h10013, 1'b0};
    vt[9]  = '{1'b0, 36'h3FFFFFFFF, 8'h13, 17'h07FFF, 1'b1};
    vt[10] = '{1'b1, 36'h7FFFFFFFF, 8'h14, 17'h17FFF, 1'b1};
    vt[11] = '{1'b0, 36'hFFFFFFFFF, 8'h01, 17'h00000, 1'b0};
    vt[12] = '{1'b0, 36'h400000000, 8'h23, 17'h00000, 1'b0};

    reset = 1'b1; cnt_clr = 1'b0; i_0_ack = 1'b1;
    t_0_dat = 36'h1; t_1_dat = 36'h2; t_cfg_0_dat = 8'h0; t_cfg_1_dat = 8'h0;
    t_0_req = 1'b1; t_1_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {35'd0, i_0_req}, 36'd0);
    check("rst_dat", {19'd0, i_0_dat}, 36'd0);
    check("rst_ack", {34'd0, t_1_ack, t_0_ack}, 36'd0);
    check("rst_cnt0", {20'd0, sat_cnt_0}, 36'd0);
    check("rst_cnt1", {20'd0, sat_cnt_1}, 36'd0);
    @(posedge clk); #1;
    reset = 1'b0; t_0_req = 1'b0; t_1_req = 1'b0;

    for (int i = 0; i < 13; i++) send(vt[i]);
    repeat (4) @(posedge clk);
    #1;
    check("cnt0_tbl", {20'd0, sat_cnt_0}, CNT_EN ? 36'(exp_sat0) : 36'd0);
    check("cnt1_tbl", {20'd0, sat_cnt_1}, CNT_EN ? 36'(exp_sat1) : 36'd0);
    check("drain_tbl", 36'(sbq.size()), 36'd0);

    // Fixed two-cycle latency from accept to i_0_req.
    t_0_dat = 36'h000000128; t_cfg_0_dat = 8'h04; t_0_req = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (t_0_ack) got = 1;
    end
    check("lat_acc", {35'd0, got}, 36'd1);
    if (got) sbq.push_back(17'h00013);
    @(posedge clk); #1;
    t_0_req = 1'b0;
    @(negedge clk);
    check("lat_n1", {35'd0, i_0_req}, 36'd0);
    @(negedge clk);
    check("lat_n2", {35'd0, i_0_req}, 36'd1);
    check("lat_dat", {19'd0, i_0_dat}, 36'h00013);
    @(posedge clk); #1;

    // Tie arbitration from reset and back-to-back throughput.
    do_reset();
    i_0_ack = 1'b1;
    gq.delete();
    start_both(2, 2);
    for (int i = 0; i < 10; i++) begin
      step();
      hist[i] = last_oreq;
    end
    go = '0;
    for (int k = 0; k < 4; k++) if (k < gq.size()) go[k] = gq[k];
    check("gnt_cnt", 36'(gq.size()), 36'd4);
    check("gnt_order", {32'd0, go}, 36'b1010);
    check("burst", {26'd0, hist}, 36'b0000111100);

    // Downstream stall: two accepts fill the pipe, then everything holds.
    i_0_ack = 1'b0;
    gq.delete();
    start_both(5, 5);
    d2 = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 2) d2 = last_odat;
    end
    check("stall_acc", 36'(gq.size()), 36'd2);
    check("stall_req", {35'd0, last_oreq}, 36'd1);
    check("stall_dat", {19'd0, last_odat}, {19'd0, d2});
    i_0_ack = 1'b1;
    left0 = t_0_req ? 1 : 0;
    left1 = t_1_req ? 1 : 0;
    repeat (8) step();
    check("drain_stall", 36'(sbq.size()), 36'd0);

    // Reset with both stages full, requests still asserted.
    i_0_ack = 1'b0;
    start_both(3, 3);
    repeat (3) step();
    reset = 1'b1;
    sbq.delete();
    @(negedge clk);
    check("rst2_ack_a", {34'd0, t_1_ack, t_0_ack}, 36'd0);
    @(negedge clk);
    check("rst2_req", {35'd0, i_0_req}, 36'd0);
    check("rst2_dat", {19'd0, i_0_dat}, 36'd0);
    check("rst2_ack_b", {34'd0, t_1_ack, t_0_ack}, 36'd0);
    @(posedge clk); #1;
    reset = 1'b0; t_0_req = 1'b0; t_1_req = 1'b0; i_0_ack = 1'b1;

    // Clear coincides with a saturated result entering the output register.
    t_0_dat = 36'h000010000; t_cfg_0_dat = 8'h00; t_0_req = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (t_0_ack) got = 1;
    end
    check("clr_acc", {35'd0, got}, 36'd1);
    if (got) sbq.push_back(17'h07FFF);
    @(posedge clk); #1;
    t_0_req = 1'b0; cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_cnt0", {20'd0, sat_cnt_0}, 36'd0);
    check("clr_cnt1", {20'd0, sat_cnt_1}, 36'd0);
    check("clr_req", {35'd0, i_0_req}, 36'd1);
    @(posedge clk); #1;
    exp_sat0 = 0;
    exp_sat1 = 0;

    // Random traffic with random downstream backpressure.
    start_both(40, 40);
    for (int i = 0; i < 150; i++) begin
      i_0_ack = 1'($urandom_range(0, 1));
      step();
    end
    i_0_ack = 1'b1;
    for (int i = 0; i < 100 && (t_0_req || t_1_req); i++) step();
    repeat (4) step();
    check("drain_rand", 36'(sbq.size()), 36'd0);
    check("cnt0_rand", {20'd0, sat_cnt_0}, CNT_EN ? 36'(exp_sat0) : 36'd0);
    check("cnt1_rand", {20'd0, sat_cnt_1}, CNT_EN ? 36'(exp_sat1) : 36'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bs_sched.md
BS_SCHED -- requirements
Module: bs_sched

Interface
REQ-001 Parameter T_DAT_WIDTH, default 36, SHALL set the accumulator input width.
REQ-002 Parameter I_DAT_WIDTH, default 16, SHALL set the finalized result width.
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set the saturation counter width.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-006 t_0_dat, t_1_dat  in  36 each  SHALL be the requester 0/1 accumulator values.
REQ-007 t_0_req, t_1_req  in  1 each  SHALL be the requester 0/1 request flags.
REQ-008 t_0_ack, t_1_ack  out  1 each  SHALL be the requester 0/1 accept strobes.
REQ-009 t_cfg_0_dat, t_cfg_1_dat  in  8 each  SHALL be per-requester config: [5:0] shift, [6] clamp-negative-to-zero, [7] ignored.
REQ-010 i_0_dat  out  17  SHALL be {source id, 16-bit result}.
REQ-011 i_0_req  out  1  SHALL be the result-valid flag; i_0_ack  in  1  SHALL be the downstream accept.
REQ-012 cnt_clr  in  1  SHALL clear the saturation counters; sat_cnt_0, sat_cnt_1  out  CNT_WIDTH  SHALL be the per-requester saturation counts.

Function
REQ-013 A transfer SHALL occur on any interface only when req and ack are both high in the same cycle; requesters hold dat and cfg stable until acked.
REQ-014 Pipeline SHALL be two registered stages: S1 captures {dat, cfg, src}, and the output register holds the finalized result.
REQ-015 S1 SHALL load when it is empty or advancing; the output register SHALL load from S1 when it is empty or i_0_ack is high.
REQ-016 Latency from input accept in cycle N to i_0_req in cycle N+2 SHALL be fixed; throughput SHALL be one result per cycle while i_0_ack is held high.
REQ-017 Arbitration SHALL be round-robin: a single request wins; with both requests, the requester not granted last wins. After reset, requester 0 SHALL win the first tie.
REQ-018 t_x_ack SHALL be combinational: the grant for requester x AND S1 can load; at most one ack per cycle.
REQ-019 Shifted value SHALL be dat arithmetically shifted right by cfg[5:0], keeping the low 16 bits.
REQ-020 Round bit SHALL be dat[shift-1] for shift 1..34 and 0 for shift 0 or >=35; the result SHALL be the shifted value plus the round bit (round half up).
REQ-021 Pre-saturation SHALL be set when dat[35:15+shift] is not all-equal, for shift 0..19; it SHALL be 0 for shift >=20.
REQ-022 Saturation SHALL be pre-saturation OR a rounding carry past 0x7FFF; on saturation the result SHALL be 0x7FFF if dat[35]=0 and 0x8000 if dat[35]=1.
REQ-023 When cfg[6]=1 and dat[35]=1, the result SHALL be 0x0000 and no saturation SHALL be counted.
REQ-024 Shift values 36..63 SHALL yield the sign-fill value (0x0000 or 0xFFFF), with no rounding and no saturation.
REQ-025 i_0_dat SHALL hold stable while i_0_req=1 and i_0_ack=0.
REQ-026 sat_cnt_x SHALL increment when a saturated result from requester x moves from S1 to the output register.
REQ-027 sat_cnt_x SHALL stick at all-ones rather than wrap.
REQ-028 When cnt_clr and an increment coincide in the same cycle, the clear SHALL win.

Reset
REQ-029 While reset is high: S1 valid, i_0_req and t_x_ack SHALL be 0; i_0_dat SHALL be 0; the round-robin pointer SHALL favor requester 0; counters SHALL be 0.
REQ-030 Reset mid-operation SHALL discard in-flight data; no result for it SHALL appear afterwards.

Configuration
REQ-031 Macro BS_SCHED_SAT_CNT_EN defined: the counters SHALL behave per REQ-026..REQ-028.
REQ-032 Macro undefined: sat_cnt_0 and sat_cnt_1 SHALL be constant 0, cnt_clr SHALL be ignored, no counter flops SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-033 cfg0=0x04, t_0_dat=0x000000128 -> i_0_dat={0,0x0013} two cycles after accept.
REQ-034 cfg0=0x00, t_0_dat=0x000010000 -> 0x7FFF, sat_cnt_0=1; cfg0=0x01, t_0_dat=0x00000FFFF -> 0x7FFF via round carry, sat_cnt_0=2.
REQ-035 t_1_dat=0xFFFFFFF00: cfg1=0x04 -> {1,0xFFF0}; cfg1=0x44 -> {1,0x0000}, sat_cnt_1 unchanged.
REQ-036 Both requests high, i_0_ack high -> grants 0,1,0,1 and 4 results in 4 consecutive cycles.
REQ-037 i_0_ack low 5 cycles with both requests high -> exactly 2 accepts, then acks stay 0 and i_0_dat stays stable; results drain in order on release.
REQ-038 Reset with both stages full, then cnt_clr coinciding with a saturated result -> i_0_req=0 the next cycle, and counters read 0.
